// File: rtl/axi_sub_rd_ctrl.sv
// AXI4 read-subordinate front end: expands AR bursts into single-outstanding beat requests
// on a simple downstream port and returns each response as an R beat.
module axi_sub_rd_ctrl #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 8,
  parameter int unsigned UW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] araddr,
  input  logic [1:0]    arburst,
  input  logic [2:0]    arsize,
  input  logic [7:0]    arlen,
  input  logic [UW-1:0] aruser,
  input  logic [IW-1:0] arid,
  input  logic          arlock,
  input  logic          arvalid,
  output logic          arready,
  output logic [DW-1:0] rdata,
  output logic [1:0]    rresp,
  output logic [IW-1:0] rid,
  output logic [UW-1:0] ruser,
  output logic          rlast,
  output logic          rvalid,
  input  logic          rready,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  output logic [2:0]    req_size,
  output logic [UW-1:0] req_user,
  input  logic          rsp_valid,
  input  logic [DW-1:0] rsp_data,
  input  logic          rsp_err
);

  localparam int unsigned MaxSize = $clog2(DW / 8);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StData} state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    burst_q;
  logic [2:0]    size_q;
  logic [7:0]    len_q;
  logic [7:0]    beat_q;
  logic [IW-1:0] id_q;
  logic [UW-1:0] user_q;
  logic          illegal_q;
  logic          arready_q;
  logic          req_valid_q;
  logic          rvalid_q;
  logic          rlast_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    rresp_q;

  logic          ar_illegal;
  logic [AW-1:0] bytes;
  logic [AW-1:0] wrap_w;
  logic [AW-1:0] next_addr;

  // Exclusive access is not supported, so the lock bit carries no meaning here.
  logic unused_arlock;
  assign unused_arlock = arlock;

  always_comb begin
    ar_illegal = 1'b0;
    if (arburst == 2'b11) ar_illegal = 1'b1;
    if (32'(arsize) > MaxSize) ar_illegal = 1'b1;
    if (arburst == BurstWrap &&
        !(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15)) begin
      ar_illegal = 1'b1;
    end
  end

  always_comb begin
    bytes  = AW'(1) << size_q;
    wrap_w = (AW'(len_q) + AW'(1)) << size_q;
    case (burst_q)
      BurstFixed: next_addr = addr_q;
      BurstIncr:  next_addr = (addr_q & ~(bytes - AW'(1))) + bytes;
      BurstWrap:  next_addr = (addr_q & ~(wrap_w - AW'(1))) |
                              ((addr_q + bytes) & (wrap_w - AW'(1)));
      default:    next_addr = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      burst_q     <= '0;
      size_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      id_q        <= '0;
      user_q      <= '0;
      illegal_q   <= 1'b0;
      arready_q   <= 1'b0;
      req_valid_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RespOkay;
    end else begin
      case (state_q)
        StIdle: begin
          // arready comes up one cycle after reset release, then stays up while idle.
          arready_q <= 1'b1;
          if (arready_q && arvalid) begin
            arready_q <= 1'b0;
            addr_q    <= araddr;
            burst_q   <= arburst;
            size_q    <= arsize;
            len_q     <= arlen;
            id_q      <= arid;
            user_q    <= aruser;
            beat_q    <= '0;
            illegal_q <= ar_illegal;
            if (ar_illegal) begin
              state_q  <= StData;
              rvalid_q <= 1'b1;
              rdata_q  <= '0;
              rresp_q  <= RespSlvErr;
              rlast_q  <= (arlen == 8'd0);
            end else begin
              state_q     <= StReq;
              req_valid_q <= 1'b1;
            end
          end
        end
        StReq: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (rsp_valid) begin
            rdata_q  <= rsp_data;
            rresp_q  <= rsp_err ? RespSlvErr : RespOkay;
            rlast_q  <= (beat_q == len_q);
            rvalid_q <= 1'b1;
            state_q  <= StData;
          end
        end
        StData: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (beat_q == len_q) begin
              state_q   <= StIdle;
              arready_q <= 1'b1;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= next_addr;
              if (illegal_q) begin
                // Illegal bursts stream SLVERR beats back-to-back without downstream traffic.
                rvalid_q <= 1'b1;
                rdata_q  <= '0;
                rresp_q  <= RespSlvErr;
                rlast_q  <= (beat_q + 8'd1 == len_q);
              end else begin
                state_q     <= StReq;
                req_valid_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arready   = arready_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign rid       = id_q;
  assign ruser     = user_q;
  assign rlast     = rlast_q;
  assign rvalid    = rvalid_q;
  assign req_valid = req_valid_q;
  assign req_addr  = addr_q;
  assign req_size  = size_q;
  assign req_user  = user_q;

endmodule

// File: tb/tb_axi_sub_rd_ctrl.sv
// Directed self-checking bench for axi_sub_rd_ctrl with hand-computed expectations.
module tb_axi_sub_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [31:0] aruser;
  logic [7:0]  arid;
  logic        arlock;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [7:0]  rid;
  logic [31:0] ruser;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_user;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [7:0]  cur_id;
  logic [31:0] cur_user;

  always #5 clk = ~clk;

  axi_sub_rd_ctrl #(.AW(32), .DW(32), .IW(8), .UW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arburst(arburst), .arsize(arsize), .arlen(arlen), .aruser(aruser),
    .arid(arid), .arlock(arlock), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rid(rid), .ruser(ruser), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_user(req_user),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [1:0] burst, input logic [2:0] size,
                         input logic [7:0] len, input logic [7:0] id, input logic [31:0] user);
    check("ar_ready_before", {63'd0, arready}, 64'd1);
    araddr = addr; arburst = burst; arsize = size; arlen = len; arid = id; aruser = user;
    arlock = 1'b1; arvalid = 1'b1;
    cur_id = id; cur_user = user;
    tick();
    arvalid = 1'b0; arlock = 1'b0;
    check("ar_ready_after", {63'd0, arready}, 64'd0);
  endtask

  task automatic serve_req(input logic [31:0] exp_addr, input logic [2:0] exp_size);
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    check("req_valid_up", {63'd0, req_valid}, 64'd1);
    check("req_addr", {32'd0, req_addr}, {32'd0, exp_addr});
    check("req_size", {61'd0, req_size}, {61'd0, exp_size});
    check("req_user", {32'd0, req_user}, {32'd0, cur_user});
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("req_valid_drop", {63'd0, req_valid}, 64'd0);
  endtask

  task automatic serve_rsp(input logic [31:0] data, input logic err, input int delay,
                           input int stall, input logic exp_last);
    logic [1:0] exp_resp;
    exp_resp = err ? 2'b10 : 2'b00;
    repeat (delay) tick();
    check("rvalid_wait", {63'd0, rvalid}, 64'd0);
    rsp_valid = 1'b1; rsp_data = data; rsp_err = err;
    tick();
    rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;
    check("rvalid_up", {63'd0, rvalid}, 64'd1);
    check("rdata", {32'd0, rdata}, {32'd0, data});
    check("rresp", {62'd0, rresp}, {62'd0, exp_resp});
    check("rlast", {63'd0, rlast}, {63'd0, exp_last});
    check("rid", {56'd0, rid}, {56'd0, cur_id});
    check("ruser", {32'd0, ruser}, {32'd0, cur_user});
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_rvalid", {63'd0, rvalid}, 64'd1);
      check("stall_rdata", {32'd0, rdata}, {32'd0, data});
      check("stall_rresp", {62'd0, rresp}, {62'd0, exp_resp});
      check("stall_rlast", {63'd0, rlast}, {63'd0, exp_last});
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_drop", {63'd0, rvalid}, 64'd0);
    if (exp_last) check("arready_after_last", {63'd0, arready}, 64'd1);
    else check("req_valid_next_beat", {63'd0, req_valid}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    araddr = '0; arburst = '0; arsize = '0; arlen = '0; aruser = '0; arid = '0;
    arlock = 1'b0; arvalid = 1'b0; rready = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    cur_id = '0; cur_user = '0;
    repeat (3) tick();
    check("rst_arready", {63'd0, arready}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("rst_rlast", {63'd0, rlast}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_req_addr", {32'd0, req_addr}, 64'd0);
    check("rst_rid", {56'd0, rid}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("arready_after_reset", {63'd0, arready}, 64'd1);

    // Single INCR beat, downstream answers 2 cycles after the request.
    send_ar(32'h100, 2'b01, 3'd2, 8'd0, 8'h5A, 32'hCAFE0001);
    serve_req(32'h100, 3'd2);
    serve_rsp(32'hDEADBEEF, 1'b0, 2, 0, 1'b1);

    // WRAP of 4 words starting at 0x1C.
    send_ar(32'h1C, 2'b10, 3'd2, 8'd3, 8'h11, 32'h0000BEEF);
    serve_req(32'h1C, 3'd2); serve_rsp(32'hA0, 1'b0, 0, 0, 1'b0);
    serve_req(32'h10, 3'd2); serve_rsp(32'hA1, 1'b0, 0, 0, 1'b0);
    serve_req(32'h14, 3'd2); serve_rsp(32'hA2, 1'b0, 1, 0, 1'b0);
    serve_req(32'h18, 3'd2); serve_rsp(32'hA3, 1'b0, 0, 0, 1'b1);

    // Unaligned INCR start.
    send_ar(32'h103, 2'b01, 3'd2, 8'd2, 8'h22, 32'h12345678);
    serve_req(32'h103, 3'd2); serve_rsp(32'hB0, 1'b0, 0, 0, 1'b0);
    serve_req(32'h104, 3'd2); serve_rsp(32'hB1, 1'b0, 0, 0, 1'b0);
    serve_req(32'h108, 3'd2); serve_rsp(32'hB2, 1'b0, 0, 0, 1'b1);

    // FIXED burst keeps the address.
    send_ar(32'h40, 2'b00, 3'd1, 8'd2, 8'h33, 32'h0);
    serve_req(32'h40, 3'd1); serve_rsp(32'hC0, 1'b0, 0, 0, 1'b0);
    serve_req(32'h40, 3'd1); serve_rsp(32'hC1, 1'b0, 0, 0, 1'b0);
    serve_req(32'h40, 3'd1); serve_rsp(32'hC2, 1'b0, 0, 0, 1'b1);

    // Illegal size 3 on a 32-bit bus: two SLVERR beats, no downstream requests.
    send_ar(32'h80, 2'b01, 3'd3, 8'd1, 8'h44, 32'h77);
    check("ill_rvalid0", {63'd0, rvalid}, 64'd1);
    check("ill_req0", {63'd0, req_valid}, 64'd0);
    check("ill_resp0", {62'd0, rresp}, 64'd2);
    check("ill_data0", {32'd0, rdata}, 64'd0);
    check("ill_last0", {63'd0, rlast}, 64'd0);
    check("ill_rid0", {56'd0, rid}, 64'h44);
    rready = 1'b1;
    tick();
    check("ill_rvalid1", {63'd0, rvalid}, 64'd1);
    check("ill_req1", {63'd0, req_valid}, 64'd0);
    check("ill_resp1", {62'd0, rresp}, 64'd2);
    check("ill_data1", {32'd0, rdata}, 64'd0);
    check("ill_last1", {63'd0, rlast}, 64'd1);
    tick();
    rready = 1'b0;
    check("ill_done_rvalid", {63'd0, rvalid}, 64'd0);
    check("ill_done_req", {63'd0, req_valid}, 64'd0);
    check("ill_done_arready", {63'd0, arready}, 64'd1);

    // Illegal WRAP length 2.
    send_ar(32'h0, 2'b10, 3'd2, 8'd2, 8'h45, 32'h0);
    check("illwrap_rvalid", {63'd0, rvalid}, 64'd1);
    check("illwrap_resp", {62'd0, rresp}, 64'd2);
    check("illwrap_req", {63'd0, req_valid}, 64'd0);
    rready = 1'b1;
    repeat (3) tick();
    rready = 1'b0;
    check("illwrap_arready", {63'd0, arready}, 64'd1);

    // Error on beat 1 does not abort; beat 0 stalls 4 cycles.
    send_ar(32'h200, 2'b01, 3'd2, 8'd2, 8'h66, 32'hABCD);
    serve_req(32'h200, 3'd2); serve_rsp(32'hD0, 1'b0, 0, 4, 1'b0);
    serve_req(32'h204, 3'd2); serve_rsp(32'hD1, 1'b1, 0, 0, 1'b0);
    serve_req(32'h208, 3'd2); serve_rsp(32'hD2, 1'b0, 0, 0, 1'b1);

    // Reset during WAIT of beat 2 of 4 discards the in-flight response.
    send_ar(32'h300, 2'b01, 3'd2, 8'd3, 8'h77, 32'h5555);
    serve_req(32'h300, 3'd2); serve_rsp(32'hE0, 1'b0, 0, 0, 1'b0);
    serve_req(32'h304, 3'd2); serve_rsp(32'hE1, 1'b0, 0, 0, 1'b0);
    serve_req(32'h308, 3'd2);
    rst_n = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hBAD0BAD0;
    tick();
    rsp_valid = 1'b0; rsp_data = 32'h0;
    check("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("mid_rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("mid_rst_arready", {63'd0, arready}, 64'd0);
    check("mid_rst_rdata", {32'd0, rdata}, 64'd0);
    check("mid_rst_rid", {56'd0, rid}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_arready", {63'd0, arready}, 64'd1);
    check("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
    send_ar(32'h400, 2'b01, 3'd2, 8'd0, 8'h88, 32'h9999);
    serve_req(32'h400, 3'd2);
    serve_rsp(32'h0F0F0F0F, 1'b0, 1, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
